// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer, LSB-first, one bit per clock
// Optional subtract mode and signed overflow flag: SERIAL_ADDER_SUB_EN
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             carry_en,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             done
`ifdef SERIAL_ADDER_SUB_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic            c;
    logic [CW-1:0]   count;
    logic            bit_s;
    logic            bit_c;

    assign bit_s = a_sh[0] ^ b_sh[0] ^ c;
    assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            c         <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
            carry_en  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            overflow  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh     <= a;
                        count    <= '0;
                        state    <= SHIFT;
                        ready    <= 1'b0;
                        carry_en <= 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
                        // a - b computed as a + ~b + 1
                        b_sh     <= sub ? ~b : b;
                        c        <= sub;
`else
                        b_sh     <= b;
                        c        <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state     <= IDLE;
                        ready     <= 1'b1;
                        carry_en  <= 1'b0;
                        sum       <= '0;
                        carry_out <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
                        overflow  <= 1'b0;
`endif
                    end else begin
                        c     <= bit_c;
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        sum   <= {bit_s, sum[WIDTH-1:1]};
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state     <= DONE;
                            carry_en  <= 1'b0;
                            done      <= 1'b1;
                            carry_out <= bit_c;
`ifdef SERIAL_ADDER_SUB_EN
                            // c is the carry into the MSB on this last bit
                            overflow  <= c ^ bit_c;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    ready    <= 1'b1;
                    carry_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
